// File: rtl/otter_io_hub_if.sv
// OTTER MCU memory-mapped I/O bus: address, write data and strobe from the
// MCU, read data back from the peripheral.
interface otter_io_hub_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;

  modport master (output iobus_addr, output iobus_out, output iobus_wr, input iobus_in);
  modport slave  (input iobus_addr, input iobus_out, input iobus_wr, output iobus_in);
endinterface

// File: rtl/otter_io_hub.sv
// Memory-mapped I/O hub: synchronised switches, debounced buttons with
// maskable W1C edge interrupts, and N_OUT read-back output registers.
module otter_io_hub #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
  parameter int unsigned N_OUT      = 3,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SW_W       = 16,
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned INTR_PULSE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  otter_io_hub_if.slave          iobus,
  input  logic [SW_W-1:0]        switches,
  input  logic [N_BTN-1:0]       buttons,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic                   intr
);

  localparam int unsigned CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [31:0] A_SW   = BASE_ADDR;
  localparam logic [31:0] A_BTN  = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_PEND = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_MASK = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_OUT0 = BASE_ADDR + 32'h10;

  logic [SW_W-1:0]             sw_sync1_q, sw_sync2_q;
  logic [N_BTN-1:0]            btn_sync1_q, btn_sync2_q;
  logic [N_BTN-1:0]            btn_db_q, btn_db_d;
  logic [N_BTN-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [N_BTN-1:0]            pend_q, pend_d;
  logic [N_BTN-1:0]            mask_q, mask_d;
  logic [N_BTN-1:0]            masked_prev_q, masked_prev_d;
  logic [N_OUT-1:0][OUT_W-1:0] out_q, out_d;
  logic                        intr_q, intr_d;

  logic                        wr_pend, wr_mask;
  logic [N_OUT-1:0]            wr_out;
  logic [N_BTN-1:0]            btn_rise, w1c_bits, masked;
  logic [31:0]                 rdata;
  logic                        unused_wdata;

  assign unused_wdata = ^iobus.iobus_out;

  // Exact-match write decode; SW/BTN and unmapped addresses have no strobe.
  always_comb begin
    wr_pend = iobus.iobus_wr && (iobus.iobus_addr == A_PEND);
    wr_mask = iobus.iobus_wr && (iobus.iobus_addr == A_MASK);
    wr_out  = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      wr_out[k] = iobus.iobus_wr && (iobus.iobus_addr == A_OUT0 + 32'(4 * k));
    end
  end

  // Debounce: level is accepted after DB_CYCLES consecutive mismatched cycles.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (btn_sync2_q[i] == btn_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_MAX) begin
        btn_db_d[i] = btn_sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Pending/mask/output next state; a new rising edge beats a same-cycle clear.
  always_comb begin
    btn_rise      = btn_db_d & ~btn_db_q;
    w1c_bits      = wr_pend ? iobus.iobus_out[N_BTN-1:0] : '0;
    pend_d        = (pend_q & ~w1c_bits) | btn_rise;
    mask_d        = wr_mask ? iobus.iobus_out[N_BTN-1:0] : mask_q;
    masked        = pend_q & mask_q;
    masked_prev_d = masked;
    intr_d        = (INTR_PULSE != 0) ? |(masked & ~masked_prev_q) : |masked;
    out_d         = out_q;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (wr_out[k]) out_d[k] = iobus.iobus_out[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1_q    <= '0;
      sw_sync2_q    <= '0;
      btn_sync1_q   <= '0;
      btn_sync2_q   <= '0;
      btn_db_q      <= '0;
      db_cnt_q      <= '0;
      pend_q        <= '0;
      mask_q        <= '0;
      masked_prev_q <= '0;
      out_q         <= '0;
      intr_q        <= 1'b0;
    end else begin
      sw_sync1_q    <= switches;
      sw_sync2_q    <= sw_sync1_q;
      btn_sync1_q   <= buttons;
      btn_sync2_q   <= btn_sync1_q;
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      masked_prev_q <= masked_prev_d;
      out_q         <= out_d;
      intr_q        <= intr_d;
    end
  end

  // Combinational, side-effect-free read mux.
  always_comb begin
    rdata = '0;
    if (iobus.iobus_addr == A_SW)   rdata = 32'(sw_sync2_q);
    if (iobus.iobus_addr == A_BTN)  rdata = 32'(btn_db_q);
    if (iobus.iobus_addr == A_PEND) rdata = 32'(pend_q);
    if (iobus.iobus_addr == A_MASK) rdata = 32'(mask_q);
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (iobus.iobus_addr == A_OUT0 + 32'(4 * k)) rdata = 32'(out_q[k]);
    end
    iobus.iobus_in = rdata;
  end

  assign out_data = out_q;
  assign intr     = intr_q;

endmodule
